// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle for the hazard unit: register addresses and control in,
// stall/flush/forward controls, error flag and perf counters out.
interface hazard_ctrl_unit_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic [RA_W-1:0]  Rs1_D, Rs2_D, Rs1_E, Rs2_E;
  logic [RA_W-1:0]  RD_E, RD_M, RD_W;
  logic             RegWriteM, RegWriteW;
  logic             ResultSrcE, PCSrcE;
  logic             MemAccessM, mem_ready_M;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
           RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, mem_ready_M,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
           RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, mem_ready_M,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding, load-use stall, branch flush,
// data-memory wait with timeout release, and saturating stall/flush counters.
module hazard_ctrl_unit #(
  parameter int RA_W        = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  hazard_ctrl_unit_if.slave hz
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       mem_stall, lw_stall;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;

  // x0 is never a forwarding source; M-stage result is newer than W, so it wins.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                         input logic we_m, input logic [RA_W-1:0] rd_m,
                                         input logic we_w, input logic [RA_W-1:0] rd_w);
    if (we_m && rd_m != '0 && rd_m == rs)      return 2'b10;
    else if (we_w && rd_w != '0 && rd_w == rs) return 2'b01;
    else                                       return 2'b00;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;

    mem_stall = hz.MemAccessM && !hz.mem_ready_M && (state_q != S_ERR);
    lw_stall  = hz.ResultSrcE && (hz.RD_E != '0) &&
                ((hz.RD_E == hz.Rs1_D) || (hz.RD_E == hz.Rs2_D));

    if (rst) begin
      fwd_a = fwd_sel(hz.Rs1_E, hz.RegWriteM, hz.RD_M, hz.RegWriteW, hz.RD_W);
      fwd_b = fwd_sel(hz.Rs2_E, hz.RegWriteM, hz.RD_M, hz.RegWriteW, hz.RD_W);
      if (mem_stall) begin
        // Whole front end freezes; a taken branch in E resolves after release.
        {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
        flush_w = 1'b1;
      end else if (hz.PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      S_RUN: begin
        if (hz.MemAccessM && !hz.mem_ready_M) begin
          state_d    = S_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      S_WAIT: begin
        if (hz.mem_ready_M) begin
          state_d    = S_RUN;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT) begin
          state_d   = S_ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_ERR: begin
        state_d    = S_RUN;
        wait_cnt_d = 8'd0;
      end
      default: state_d = S_RUN;
    endcase

    if (stall_f && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_d && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.mem_err   = mem_err_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with CNT_W=4 and MEM_TIMEOUT=4 so counter
// saturation and the timeout release are reachable in a few cycles.
module tb_hazard_ctrl_unit;

  localparam int RA_W        = 5;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl_unit_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();

  hazard_ctrl_unit #(.RA_W(RA_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; combinational checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.Rs1_D = '0; bus.Rs2_D = '0; bus.Rs1_E = '0; bus.Rs2_E = '0;
    bus.RD_E = '0; bus.RD_M = '0; bus.RD_W = '0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0;
    bus.ResultSrcE = 1'b0; bus.PCSrcE = 1'b0;
    bus.MemAccessM = 1'b0; bus.mem_ready_M = 1'b1;
  endtask

  function automatic logic [3:0] stalls4();
    return {bus.StallF, bus.StallD, bus.StallE, bus.StallM};
  endfunction

  function automatic logic [2:0] flushes3();
    return {bus.FlushD, bus.FlushE, bus.FlushW};
  endfunction

  initial begin
    clear_inputs();

    // Reset: hazard-producing inputs present, but every control output held at 0.
    rst = 1'b0;
    bus.RegWriteM = 1'b1; bus.RD_M = 5'd5; bus.Rs1_E = 5'd5;
    bus.MemAccessM = 1'b1; bus.mem_ready_M = 1'b0; bus.PCSrcE = 1'b1;
    settle();
    check("rst_fwd_a", 16'(bus.ForwardAE), 16'h0);
    check("rst_stalls", 16'(stalls4()), 16'h0);
    check("rst_flushes", 16'(flushes3()), 16'h0);
    tick();
    tick();
    check("rst_stall_cnt", 16'(bus.stall_cnt), 16'h0);
    check("rst_flush_cnt", 16'(bus.flush_cnt), 16'h0);
    check("rst_mem_err", 16'(bus.mem_err), 16'h0);
    clear_inputs();
    rst = 1'b1;
    settle();

    // Forwarding: M beats W, x0 never forwarded, W used when M not writing.
    bus.RegWriteM = 1'b1; bus.RD_M = 5'd5; bus.RegWriteW = 1'b1; bus.RD_W = 5'd5;
    bus.Rs1_E = 5'd5; bus.Rs2_E = 5'd6;
    settle();
    check("fwd_m_over_w", 16'(bus.ForwardAE), 16'h2);
    check("fwd_b_none", 16'(bus.ForwardBE), 16'h0);
    bus.RD_M = 5'd0;
    settle();
    check("fwd_w_when_rdm0", 16'(bus.ForwardAE), 16'h1);
    bus.RD_W = 5'd0; bus.Rs1_E = 5'd0; bus.Rs2_E = 5'd0;
    settle();
    check("fwd_x0_a", 16'(bus.ForwardAE), 16'h0);
    check("fwd_x0_b", 16'(bus.ForwardBE), 16'h0);
    bus.RegWriteM = 1'b0; bus.RD_M = 5'd9; bus.RD_W = 5'd9; bus.Rs2_E = 5'd9;
    settle();
    check("fwd_b_w_no_regwm", 16'(bus.ForwardBE), 16'h1);
    bus.RegWriteM = 1'b1;
    settle();
    check("fwd_b_m", 16'(bus.ForwardBE), 16'h2);
    check("no_stall_fwd_only", 16'(stalls4()), 16'h0);
    clear_inputs();
    tick();

    // Load-use on Rs2_D.
    bus.ResultSrcE = 1'b1; bus.RD_E = 5'd7; bus.Rs2_D = 5'd7;
    settle();
    check("lw_stalls", 16'(stalls4()), 16'b1100);
    check("lw_flushes", 16'(flushes3()), 16'b010);
    tick();
    check("lw_stall_cnt", 16'(bus.stall_cnt), 16'h1);
    bus.RD_E = 5'd0; bus.Rs2_D = 5'd0;
    settle();
    check("lw_x0_ignored", 16'(stalls4()), 16'h0);

    // Load-use and taken branch together: branch flush wins, PC not stalled.
    bus.RD_E = 5'd3; bus.Rs1_D = 5'd3; bus.PCSrcE = 1'b1;
    settle();
    check("br_lw_stalls", 16'(stalls4()), 16'h0);
    check("br_lw_flushes", 16'(flushes3()), 16'b110);
    tick();
    check("br_flush_cnt", 16'(bus.flush_cnt), 16'h1);
    check("br_stall_cnt", 16'(bus.stall_cnt), 16'h1);
    clear_inputs();

    // Reset pulse clears counters.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst2_stall_cnt", 16'(bus.stall_cnt), 16'h0);
    check("rst2_flush_cnt", 16'(bus.flush_cnt), 16'h0);

    // Memory wait of 3 cycles; a taken branch during the wait is frozen.
    bus.MemAccessM = 1'b1; bus.mem_ready_M = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.PCSrcE = (i == 1);
      settle();
      check($sformatf("mw_stalls_%0d", i), 16'(stalls4()), 16'b1111);
      check($sformatf("mw_flushes_%0d", i), 16'(flushes3()), 16'b001);
      tick();
    end
    bus.PCSrcE = 1'b0; bus.mem_ready_M = 1'b1;
    settle();
    check("mw_release", 16'(stalls4()), 16'h0);
    tick();
    check("mw_stall_cnt", 16'(bus.stall_cnt), 16'h3);
    check("mw_flush_cnt", 16'(bus.flush_cnt), 16'h0);
    check("mw_mem_err", 16'(bus.mem_err), 16'h0);

    // Timeout: 5 stall cycles, then ERR release cycle with no stall, error sticky.
    bus.mem_ready_M = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("to_stall_%0d", i), 16'(stalls4()), 16'b1111);
      check($sformatf("to_err_%0d", i), 16'(bus.mem_err), 16'h0);
      tick();
    end
    settle();
    check("to_err_cycle_stall", 16'(stalls4()), 16'h0);
    check("to_err_cycle_flushw", 16'(bus.FlushW), 16'h0);
    check("to_mem_err", 16'(bus.mem_err), 16'h1);
    tick();
    settle();
    check("to_restall", 16'(stalls4()), 16'b1111);
    tick();
    check("to_stall_cnt", 16'(bus.stall_cnt), 16'h9);
    clear_inputs();
    tick();
    check("to_mem_err_sticky", 16'(bus.mem_err), 16'h1);

    // Saturation of both counters.
    bus.ResultSrcE = 1'b1; bus.RD_E = 5'd4; bus.Rs1_D = 5'd4;
    repeat (20) tick();
    check("sat_stall_cnt", 16'(bus.stall_cnt), 16'hF);
    check("sat_flush_cnt_idle", 16'(bus.flush_cnt), 16'h0);
    clear_inputs();
    bus.PCSrcE = 1'b1;
    repeat (20) tick();
    check("sat_flush_cnt", 16'(bus.flush_cnt), 16'hF);
    check("sat_stall_cnt_hold", 16'(bus.stall_cnt), 16'hF);
    clear_inputs();

    // One-cycle reset clears everything, including the sticky error.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst3_stall_cnt", 16'(bus.stall_cnt), 16'h0);
    check("rst3_flush_cnt", 16'(bus.flush_cnt), 16'h0);
    check("rst3_mem_err", 16'(bus.mem_err), 16'h0);

    // Reset mid-wait: a still-pending access restarts its wait count from 1.
    bus.MemAccessM = 1'b1; bus.mem_ready_M = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("midrst_stalls", 16'(stalls4()), 16'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("midrst_stall_%0d", i), 16'(bus.StallF), 16'h1);
      tick();
    end
    settle();
    check("midrst_err_cycle", 16'(bus.StallF), 16'h0);
    check("midrst_mem_err", 16'(bus.mem_err), 16'h1);
    check("midrst_stall_cnt", 16'(bus.stall_cnt), 16'h5);
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
